alarm_ringer: RTL and testbench

- Downstream consumer of the alarm comparator's `active` level.
- Turns the first cycle of a match into a timed ringing session with a 1 Hz beep pattern, snooze, dismiss and auto-timeout.
- Drives the buzzer pin and the ringing/snooze status shown on the display.
- Edge-detects `active`, so a dismissed alarm does not re-ring during the same matching minute.

---
 rtl/alarm_ringer_if.sv | 22 ++
 rtl/alarm_ringer.sv | 114 +++++++++++
 tb/tb_alarm_ringer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alarm_ringer_if.sv
// Signal bundle between the alarm comparator/buttons side and the ringer.
// master drives the stimulus side, slave is the ringer itself.
interface alarm_ringer_if;
  logic       active;
  logic       sec_tick;
  logic       snooze_btn;
  logic       stop_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [3:0] snooze_cnt;

  modport master (
    output active, sec_tick, snooze_btn, stop_btn,
    input  buzzer, ringing, snoozing, snooze_cnt
  );

  modport slave (
    input  active, sec_tick, snooze_btn, stop_btn,
    output buzzer, ringing, snoozing, snooze_cnt
  );
endinterface

// File: rtl/alarm_ringer.sv
// Alarm ringer: turns the rising edge of 'active' into a timed ring session with
// 1 Hz beep, snooze, dismiss and timeout. ALARM_RINGER_ESCALATE_EN: steady buzzer after a snooze.
module alarm_ringer #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic          clk,
  input  logic          rst,
  alarm_ringer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t      state, state_n;
  logic        active_q;
  logic [15:0] sec_cnt, sec_cnt_n;
  logic        phase, phase_n;
  logic [3:0]  snz_cnt, snz_cnt_n;
  logic        buzzer_q, buzzer_n;
  logic        ringing_q, snoozing_q;
  logic        rise;

  assign rise = bus.active & ~active_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      active_q   <= 1'b0;
      sec_cnt    <= '0;
      phase      <= 1'b0;
      snz_cnt    <= '0;
      buzzer_q   <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state      <= state_n;
      active_q   <= bus.active;
      sec_cnt    <= sec_cnt_n;
      phase      <= phase_n;
      snz_cnt    <= snz_cnt_n;
      buzzer_q   <= buzzer_n;
      ringing_q  <= (state_n == RING);
      snoozing_q <= (state_n == SNOOZE);
    end
  end

  always_comb begin
    state_n   = state;
    sec_cnt_n = sec_cnt;
    phase_n   = phase;
    snz_cnt_n = snz_cnt;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n   = RING;
          sec_cnt_n = '0;
          phase_n   = 1'b1;
          snz_cnt_n = '0;
        end
      end
      RING: begin
        // stop beats snooze beats tick; a refused snooze lets the tick through
        if (bus.stop_btn) begin
          state_n   = IDLE;
          sec_cnt_n = '0;
          phase_n   = 1'b0;
        end else if (bus.snooze_btn && (snz_cnt < 4'(MAX_SNOOZE))) begin
          state_n   = SNOOZE;
          snz_cnt_n = snz_cnt + 4'd1;
          sec_cnt_n = '0;
          phase_n   = 1'b0;
        end else if (bus.sec_tick) begin
          if (sec_cnt == 16'(RING_SEC - 1)) begin
            state_n   = IDLE;
            sec_cnt_n = '0;
            phase_n   = 1'b0;
          end else begin
            sec_cnt_n = sec_cnt + 16'd1;
            phase_n   = ~phase;
          end
        end
      end
      SNOOZE: begin
        if (bus.stop_btn) begin
          state_n   = IDLE;
          sec_cnt_n = '0;
          phase_n   = 1'b0;
        end else if (bus.sec_tick) begin
          if (sec_cnt == 16'(SNOOZE_SEC - 1)) begin
            state_n   = RING;
            sec_cnt_n = '0;
            phase_n   = 1'b1;
          end else begin
            sec_cnt_n = sec_cnt + 16'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef ALARM_RINGER_ESCALATE_EN
  assign buzzer_n = (state_n == RING) & (phase_n | (snz_cnt_n != 4'd0));
`else
  assign buzzer_n = (state_n == RING) & phase_n;
`endif

  assign bus.buzzer     = buzzer_q;
  assign bus.ringing    = ringing_q;
  assign bus.snoozing   = snoozing_q;
  assign bus.snooze_cnt = snz_cnt;

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: directed scenarios plus random buttons/active,
// scored against a second-counting reference model through an expectation queue.
module tb_alarm_ringer;
  localparam int RING_SEC   = 4;
  localparam int SNOOZE_SEC = 3;
  localparam int MAX_SNOOZE = 2;

  typedef struct packed {
    logic       buz;
    logic       rng;
    logic       snz;
    logic [3:0] cnt;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  alarm_ringer_if bus ();

  alarm_ringer #(.RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC), .MAX_SNOOZE(MAX_SNOOZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  out_t expq[$];
  int   cyc = 0;

  // stimulus knobs set by scenario code, pulses auto-clear after each step
  logic act = 1'b0, sb = 1'b0, st = 1'b0;

  // reference model: which activity is going on, whole seconds spent in it, snoozes used
  bit m_prev, m_ringing, m_snoozing;
  int m_secs, m_used;

  function automatic void model_reset();
    m_prev = 0; m_ringing = 0; m_snoozing = 0; m_secs = 0; m_used = 0;
  endfunction

  function automatic out_t model_step(bit a, bit tick, bit snz, bit stp);
    out_t o;
    bit   rise = a && !m_prev;
    m_prev = a;
    if (m_ringing) begin
      if (stp) m_ringing = 0;
      else if (snz && m_used < MAX_SNOOZE) begin
        m_ringing = 0; m_snoozing = 1; m_used++; m_secs = 0;
      end else if (tick) begin
        m_secs++;
        if (m_secs == RING_SEC) m_ringing = 0;
      end
    end else if (m_snoozing) begin
      if (stp) m_snoozing = 0;
      else if (tick) begin
        m_secs++;
        if (m_secs == SNOOZE_SEC) begin m_snoozing = 0; m_ringing = 1; m_secs = 0; end
      end
    end else if (rise) begin
      m_ringing = 1; m_secs = 0; m_used = 0;
    end
    // beep is on during even-numbered seconds of a ring session
`ifdef ALARM_RINGER_ESCALATE_EN
    o.buz = m_ringing && ((m_secs % 2 == 0) || m_used >= 1);
`else
    o.buz = m_ringing && (m_secs % 2 == 0);
`endif
    o.rng = m_ringing;
    o.snz = m_snoozing;
    o.cnt = 4'(m_used);
    return o;
  endfunction

  task automatic step();
    bit tick;
    @(negedge clk);
    tick = (cyc % 10 == 9);
    bus.active     = act;
    bus.sec_tick   = tick;
    bus.snooze_btn = sb;
    bus.stop_btn   = st;
    expq.push_back(model_step(act, tick, sb, st));
    sb = 1'b0; st = 1'b0;
    cyc++;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // advance so the next step() lands on a sec_tick cycle
  task automatic to_tick();
    while (cyc % 10 != 9) step();
  endtask

  // monitor: one expectation per clock edge
  always @(posedge clk) begin
    out_t exp, got;
    #1;
    if (expq.size() > 0) begin
      exp = expq.pop_front();
      got = '{bus.buzzer, bus.ringing, bus.snoozing, bus.snooze_cnt};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL out@%0t got buz=%b rng=%b snz=%b cnt=%0d exp buz=%b rng=%b snz=%b cnt=%0d",
                 $time, got.buz, got.rng, got.snz, got.cnt, exp.buz, exp.rng, exp.snz, exp.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.active = 1'b0; bus.sec_tick = 1'b0; bus.snooze_btn = 1'b0; bus.stop_btn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    steps(5);

    // basic ring: hold active through timeout, no re-ring
    act = 1; steps(60); act = 0; steps(3);
    // dismiss on second ringing clk, then re-arm
    act = 1; steps(2); st = 1; step(); steps(2);
    act = 0; step(); act = 1; steps(5);
    // snooze, re-ring after three ticks
    sb = 1; step(); steps(40);
    // second snooze hits the limit, third press ignored, then timeout
    sb = 1; step(); steps(40);
    sb = 1; step(); steps(50);
    act = 0; steps(2);
    // stop + snooze + tick together
    act = 1; step(); to_tick(); st = 1; sb = 1; step(); steps(3);
    act = 0; step();
    // stop while snoozing cancels re-ring
    act = 1; steps(3); sb = 1; step(); steps(4); st = 1; step(); steps(40);
    act = 0; step();

    // random phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(79) == 0) act = ~act;
      sb = ($urandom_range(24) == 0);
      st = ($urandom_range(59) == 0);
      step();
    end

    // asynchronous reset mid-ring
    act = 0; steps(2); act = 1; steps(4);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.buzzer, bus.ringing, bus.snoozing, bus.snooze_cnt} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got buz=%b rng=%b snz=%b cnt=%0d exp all 0",
               bus.buzzer, bus.ringing, bus.snoozing, bus.snooze_cnt);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // active still high at release rings on the first clk
    steps(30);
    act = 0; steps(5);

    begin
      int budget = 10;
      while (expq.size() > 0 && budget > 0) begin @(posedge clk); budget--; end
      #2;
      if (expq.size() > 0) begin
        checks++; errors++;
        $display("FAIL drain got %0d pending exp 0", expq.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
